fma_align_shamt_stage: RTL

//  Elastic 2-stage pipeline directly upstream of the addend aligner. Takes raw

---
 rtl/fma_align_shamt_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fma_align_shamt_stage.sv
// ----------------------------------------------------------------------------
// fma_align_shamt_stage
//
// Purpose:
//   Elastic two-stage pipeline that sits directly in front of the FMA addend
//   aligner. From the raw exponent fields of A, B and C and the fraction of C
//   it produces C's significand with the hidden bit, the clamped right-shift
//   amount the aligner applies to {0, C, 54'b0}, and the tentative product
//   exponent that the adder/normalise stages need later on.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   input beat valid
//   in_ready   stage can accept a beat (combinational from out_ready)
//   ea, eb, ec biased exponent fields of A, B, C
//   fc         fraction field of C
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   c_sig      C significand including the hidden bit
//   shamt      clamped alignment shift, 0..MAX_SHAMT
//   prod_exp   signed tentative product exponent ea'+eb'-BIAS
//   c_dom      unclamped shift was negative (C far exceeds the product)
//   c_under    unclamped shift exceeded MAX_SHAMT (C is entirely sticky)
// ----------------------------------------------------------------------------
module fma_align_shamt_stage #(
    parameter int EXP_WIDTH   = 8,
    parameter int SIG_WIDTH   = 23,
    parameter int SHAMT_WIDTH = 7,
    parameter int BIAS        = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_WIDTH-1:0]   ea,
    input  logic [EXP_WIDTH-1:0]   eb,
    input  logic [EXP_WIDTH-1:0]   ec,
    input  logic [SIG_WIDTH-1:0]   fc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIG_WIDTH:0]     c_sig,
    output logic [SHAMT_WIDTH-1:0] shamt,
    output logic [EXP_WIDTH+1:0]   prod_exp,
    output logic                   c_dom,
    output logic                   c_under
);

    localparam int SHAMT_OFFSET = SIG_WIDTH + 4;
    localparam int MAX_SHAMT    = 3 * (SIG_WIDTH + 1) + 6;
    localparam int PW           = EXP_WIDTH + 2;
    localparam int DW           = EXP_WIDTH + 3;

    logic                   s1_valid;
    logic                   s2_valid;
    logic                   s1_adv;
    logic                   s2_adv;

    logic [EXP_WIDTH-1:0]   ea_eff;
    logic [EXP_WIDTH-1:0]   eb_eff;
    logic [EXP_WIDTH-1:0]   ec_eff;
    logic signed [PW-1:0]   prod_next;

    logic [PW-1:0]          s1_prod;
    logic [EXP_WIDTH-1:0]   s1_ec;
    logic [SIG_WIDTH:0]     s1_sig;

    logic signed [DW-1:0]   d;
    logic [SHAMT_WIDTH-1:0] shamt_next;
    logic                   dom_next;
    logic                   under_next;

    // Handshake: stage 2 frees up when drained or empty; stage 1 can take a
    // new beat whenever it is empty or its current beat moves on.
    assign s2_adv    = out_ready || !s2_valid;
    assign s1_adv    = s1_valid && s2_adv;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;

    // Stage-1 datapath: a zero exponent field (zero/subnormal) behaves as
    // exponent 1; the hidden bit of C is set only for normal encodings.
    always_comb begin
        ea_eff    = (ea == '0) ? EXP_WIDTH'(1) : ea;
        eb_eff    = (eb == '0) ? EXP_WIDTH'(1) : eb;
        ec_eff    = (ec == '0) ? EXP_WIDTH'(1) : ec;
        prod_next = $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff})
                  - $signed(PW'(BIAS));
    end

    // Stage-2 datapath: the unclamped shift is computed one bit wider than
    // the product exponent so that every input combination fits without
    // wrapping; the sign bit alone decides the C-dominant case.
    always_comb begin
        d = $signed({s1_prod[PW-1], s1_prod}) - $signed({3'b000, s1_ec})
          + $signed(DW'(SHAMT_OFFSET));
        shamt_next = d[SHAMT_WIDTH-1:0];
        dom_next   = 1'b0;
        under_next = 1'b0;
        if (d[DW-1]) begin
            shamt_next = '0;
            dom_next   = 1'b1;
        end else if (d > $signed(DW'(MAX_SHAMT))) begin
            shamt_next = SHAMT_WIDTH'(MAX_SHAMT);
            under_next = 1'b1;
        end
    end

    // Stage-1 register: occupancy follows in_valid whenever the slot is free
    // to change; payload only loads on an actual transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_ec    <= '0;
            s1_sig   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_prod <= prod_next;
                s1_ec   <= ec_eff;
                s1_sig  <= {(ec != '0), fc};
            end
        end
    end

    // Stage-2 register drives the outputs directly, so a stalled beat keeps
    // its payload untouched until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            c_sig    <= '0;
            shamt    <= '0;
            prod_exp <= '0;
            c_dom    <= 1'b0;
            c_under  <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv) begin
                c_sig    <= s1_sig;
                shamt    <= shamt_next;
                prod_exp <= s1_prod;
                c_dom    <= dom_next;
                c_under  <= under_next;
            end
        end
    end

endmodule
